mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory stage directly downstream of Execute. Takes Execute's data_out (result/effective
//  address), the rt store operand and insn. Performs MIPS loads/stores (LB/LBU/LH/LHU/LW,
//  SB/SH/SW) over a req/ack data-memory port and forwards non-memory results unchanged
//  to writeback. Stalls upstream via in_ready while an access is outstanding. Big-endian.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles mem_req may wait for mem_ack before abort; 0 = no limit
// PORTS
//  clock       in   1      single clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  in_valid    in   1      Execute presents a valid instruction this cycle
//  in_ready    out  1      stage can accept (combinational: state==IDLE)
//  insn        in   [0:31] instruction; opcode = insn[0:5]
//  pc          in   [0:31] instruction PC, carried to output
//  alu_result  in   [0:31] Execute data_out; effective address for mem ops
//  rt          in   [0:31] store data operand
//  in_wb       in   1      non-mem op writes register file
//  mem_req     out  1      access request, held until ack/abort
//  mem_we      out  1      1 = store
//  mem_addr    out  [0:31] word address: {alu_result[0:29],2'b00}
//  mem_be      out  [0:3]  byte enables; be[k] = byte at offset k = bits [8k:8k+7]
//  mem_wdata   out  [0:31] store data, lane-replicated
//  mem_ack     in   1      memory completes access at this edge
//  mem_rdata   in   [0:31] read word, valid when mem_ack=1
//  out_valid   out  1      one-cycle pulse: result for writeback
//  out_data    out  [0:31] load data / passthrough result / 0 for stores and faults
//  out_wb      out  1      writeback enable
//  out_pc      out  [0:31] pc of retiring instruction
//  out_fault   out  1      misaligned or timed-out access
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; mem_req, mem_we, out_valid, out_wb, out_fault=0;
//   mem_addr, mem_be, mem_wdata, out_data, out_pc=0; timeout counter=0. Outstanding
//   access dropped immediately; a late mem_ack after reset is ignored.
//  FSM IDLE/WAIT. Accept on edge with in_valid & in_ready.
//  IDLE, non-mem opcode: next cycle out_valid=1, out_data=alu_result, out_wb=in_wb.
//   Latency 1, back-to-back acceptance every cycle.
//  IDLE, mem opcode, aligned: register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata;
//   go WAIT. Address/be/wdata stable while mem_req=1.
//  Alignment: LH/LHU/SH need addr[31]=0; LW/SW need addr[30:31]=0. Misaligned: no request,
//   next cycle out_valid=1, out_fault=1, out_wb=0, out_data=0.
//  Store lanes: SB be=one-hot at offset, wdata={4{rt[24:31]}}; SH be=1100/0011 for
//   offset 0/2, wdata={2{rt[16:31]}}; SW be=1111, wdata=rt. Loads drive be=1111.
//  WAIT: counter increments each cycle. On mem_ack edge: mem_req=0, out_valid=1 next
//   cycle, return to IDLE (in_ready high again same cycle as out_valid).
//   Load: LB/LBU select byte rdata[8k:8k+7], sign/zero extend; LH/LHU select halfword
//   offset 0/2, extend; LW whole word; out_wb=1. Store: out_data=0, out_wb=0.
//  Timeout: counter reaches TIMEOUT_CYCLES without ack -> mem_req=0, out_fault=1,
//   out_valid=1, out_wb=0, IDLE. Ack arriving same edge as expiry wins (normal completion).
//  out_valid, out_fault are single-cycle pulses; out_data/out_pc hold until next result.
// TESTING
//  ADD passthrough: alu_result=0x00000010, in_wb=1 -> next cycle out_valid, out_data=0x10, out_wb=1.
//  LB addr 0x1003, rdata=0x11223380 ack after 3 cycles -> mem_be=1111, out_data=0xFFFFFF80; LBU -> 0x00000080.
//  SH addr 0x2002, rt=0xDEADBEEF -> mem_be=0011, mem_wdata=0xBEEFBEEF, mem_we=1, out_wb=0.
//  LW addr 0x3001 -> no mem_req, out_fault=1, out_data=0, out_wb=0.
//  TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 WAIT cycles, out_fault pulse, in_ready returns.
//  Assert reset_n low during WAIT -> mem_req low immediately; late ack ignored; next LW completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: MIPS byte/half/word loads and stores over a req/ack port, ALU passthrough otherwise.
// Big-endian: byte lane 0 is bits [31:24] and mem_be[3]; in_ready drops while an access is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] insn,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt,
  input  logic        in_wb,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_wb,
  output logic [31:0] out_pc,
  output logic        out_fault
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    op_q;
  logic [1:0]    off_q;
  logic [31:0]   pc_q;

  logic [5:0]  op;
  logic [1:0]  off;
  logic        is_load, is_store, is_half, is_word, misaligned;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic        unused_insn;

  assign op          = insn[31:26];
  assign off         = alu_result[1:0];
  assign in_ready    = (state == S_IDLE);
  assign unused_insn = ^insn[25:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    be_nx    = 4'b1111;
    wdata_nx = rt;
    case (op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
      OP_SB: begin
        is_store = 1'b1;
        be_nx    = 4'b1000 >> off;
        wdata_nx = {4{rt[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        is_half  = 1'b1;
        be_nx    = off[1] ? 4'b0011 : 4'b1100;
        wdata_nx = {2{rt[15:0]}};
      end
      OP_SW: begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
    misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));
  end

  // Lane extraction uses the offset captured at request time, not the live input.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'h0, rd_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      off_q     <= '0;
      pc_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_wb    <= 1'b0;
      out_pc    <= '0;
      out_fault <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (!(is_load || is_store)) begin
              out_valid <= 1'b1;
              out_data  <= alu_result;
              out_wb    <= in_wb;
              out_pc    <= pc;
            end else if (misaligned) begin
              out_valid <= 1'b1;
              out_fault <= 1'b1;
              out_data  <= '0;
              out_wb    <= 1'b0;
              out_pc    <= pc;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_be    <= be_nx;
              mem_wdata <= wdata_nx;
              op_q      <= op;
              off_q     <= off;
              pc_q      <= pc;
              cnt       <= '0;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Ack is checked first so an ack on the expiry edge completes normally.
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= mem_we ? 32'h0 : load_data;
            out_wb    <= !mem_we;
            out_pc    <= pc_q;
            state     <= S_IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            out_valid <= 1'b1;
            out_fault <= 1'b1;
            out_data  <= '0;
            out_wb    <= 1'b0;
            out_pc    <= pc_q;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT_CYCLES=4): vector table plus timeout, reset and back-to-back sequences.
module tb_mem_access_stage;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] insn, pc, alu_result, rt;
  logic        in_wb;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_wb;
  logic [31:0] out_pc;
  logic        out_fault;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .insn(insn), .pc(pc), .alu_result(alu_result), .rt(rt), .in_wb(in_wb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_wb(out_wb), .out_pc(out_pc),
    .out_fault(out_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        in_wb;
    logic [31:0] rdata;
    int          delay;   // cycles in WAIT until ack; 0 = no request expected
    logic        e_we;
    logic [3:0]  e_be;
    logic        chk_wd;
    logic [31:0] e_wd;
    logic [31:0] e_data;
    logic        e_wb;
    logic        e_fault;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    logic [31:0] vpc;
    t   = $sformatf("v%0d", idx);
    vpc = 32'h0040_0000 + 32'(idx * 4);
    insn = {v.op, 26'h0}; pc = vpc; alu_result = v.addr; rt = v.rt; in_wb = v.in_wb;
    in_valid = 1'b1;
    chk({t, ".in_ready_pre"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    if (v.delay > 0) begin
      chk({t, ".mem_req"}, mem_req, 1);
      chk({t, ".mem_we"}, mem_we, v.e_we);
      chk({t, ".mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
      chk({t, ".mem_be"}, mem_be, v.e_be);
      if (v.chk_wd) chk({t, ".mem_wdata"}, mem_wdata, v.e_wd);
      chk({t, ".in_ready_wait"}, in_ready, 0);
      chk({t, ".out_valid_wait"}, out_valid, 0);
      for (int i = 1; i < v.delay; i++) step();
      chk({t, ".mem_req_held"}, mem_req, 1);
      mem_ack = 1'b1; mem_rdata = v.rdata;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
    end
    chk({t, ".out_valid"}, out_valid, 1);
    chk({t, ".out_data"}, out_data, v.e_data);
    chk({t, ".out_wb"}, out_wb, v.e_wb);
    chk({t, ".out_fault"}, out_fault, v.e_fault);
    chk({t, ".out_pc"}, out_pc, vpc);
    chk({t, ".in_ready_post"}, in_ready, 1);
    chk({t, ".mem_req_post"}, mem_req, 0);
    step();
    chk({t, ".out_valid_pulse"}, out_valid, 0);
    chk({t, ".out_fault_pulse"}, out_fault, 0);
    chk({t, ".out_data_hold"}, out_data, v.e_data);
  endtask

  initial begin
    vec_t lw;
    vecs[0]  = '{6'h00, 32'h0000_0010, 32'h0, 1'b1, 32'h0, 0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0000_0010, 1'b1, 1'b0};
    vecs[1]  = '{6'h20, 32'h0000_1003, 32'h0, 1'b0, 32'h1122_3380, 3, 1'b0, 4'b1111, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[2]  = '{6'h24, 32'h0000_1003, 32'h0, 1'b0, 32'h1122_3380, 3, 1'b0, 4'b1111, 1'b0, 32'h0, 32'h0000_0080, 1'b1, 1'b0};
    vecs[3]  = '{6'h23, 32'h0000_3001, 32'h0, 1'b1, 32'h0, 0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[4]  = '{6'h29, 32'h0000_2002, 32'hDEAD_BEEF, 1'b1, 32'h0, 1, 1'b1, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{6'h21, 32'h0000_4002, 32'h0, 1'b0, 32'h1234_8765, 2, 1'b0, 4'b1111, 1'b0, 32'h0, 32'hFFFF_8765, 1'b1, 1'b0};
    vecs[6]  = '{6'h25, 32'h0000_4000, 32'h0, 1'b0, 32'h8765_1234, 1, 1'b0, 4'b1111, 1'b0, 32'h0, 32'h0000_8765, 1'b1, 1'b0};
    vecs[7]  = '{6'h23, 32'h0000_5000, 32'h0, 1'b0, 32'hCAFE_F00D, 4, 1'b0, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[8]  = '{6'h28, 32'h0000_6001, 32'h0000_00A5, 1'b0, 32'h0, 1, 1'b1, 4'b0100, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{6'h2B, 32'h0000_7004, 32'h0123_4567, 1'b0, 32'h0, 2, 1'b1, 4'b1111, 1'b1, 32'h0123_4567, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{6'h21, 32'h0000_4001, 32'h0, 1'b0, 32'h0, 0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[11] = '{6'h0F, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 0, 1'b0, 4'h0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[12] = '{6'h20, 32'h0000_1001, 32'h0, 1'b0, 32'h00AB_0000, 1, 1'b0, 4'b1111, 1'b0, 32'h0, 32'hFFFF_FFAB, 1'b1, 1'b0};
    vecs[13] = '{6'h20, 32'h0000_1000, 32'h0, 1'b0, 32'h7F00_0000, 1, 1'b0, 4'b1111, 1'b0, 32'h0, 32'h0000_007F, 1'b1, 1'b0};
    vecs[14] = '{6'h29, 32'h0000_2000, 32'h0000_1234, 1'b0, 32'h0, 1, 1'b1, 4'b1100, 1'b1, 32'h1234_1234, 32'h0, 1'b0, 1'b0};
    vecs[15] = '{6'h2B, 32'h0000_3002, 32'h1111_1111, 1'b0, 32'h0, 0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};

    reset_n = 1'b0; in_valid = 1'b0; insn = '0; pc = '0; alu_result = '0; rt = '0;
    in_wb = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_fault", out_fault, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.out_pc", out_pc, 0);
    chk("rst.mem_be", mem_be, 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Back-to-back passthrough: one result per cycle.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      insn = 32'h0; alu_result = 32'hA0 + 32'(k); pc = 32'h100 + 32'(k); in_wb = k[0];
      step();
      chk($sformatf("b2b%0d.out_valid", k), out_valid, 1);
      chk($sformatf("b2b%0d.out_data", k), out_data, 32'hA0 + 32'(k));
      chk($sformatf("b2b%0d.out_wb", k), out_wb, {31'h0, k[0]});
      chk($sformatf("b2b%0d.in_ready", k), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b.idle_valid", out_valid, 0);
    chk("b2b.data_hold", out_data, 32'hA2);
    chk("b2b.pc_hold", out_pc, 32'h102);

    // Timeout: no ack, request held for exactly 4 WAIT cycles.
    insn = {6'h23, 26'h0}; alu_result = 32'h8000; pc = 32'h200; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("to%0d.mem_req", k), mem_req, 1);
      chk($sformatf("to%0d.in_ready", k), in_ready, 0);
      step();
    end
    chk("to3.mem_req", mem_req, 1);
    chk("to3.out_valid", out_valid, 0);
    step();
    chk("to.mem_req_drop", mem_req, 0);
    chk("to.out_valid", out_valid, 1);
    chk("to.out_fault", out_fault, 1);
    chk("to.out_wb", out_wb, 0);
    chk("to.out_data", out_data, 0);
    chk("to.out_pc", out_pc, 32'h200);
    chk("to.in_ready", in_ready, 1);
    step();
    chk("to.fault_pulse", out_fault, 0);

    // Reset during WAIT, then a late ack that must be ignored.
    insn = {6'h23, 26'h0}; alu_result = 32'h9000; pc = 32'h300; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rw.mem_req", mem_req, 1);
    step();
    reset_n = 1'b0;
    #1;
    chk("rw.req_async", mem_req, 0);
    chk("rw.in_ready", in_ready, 1);
    chk("rw.mem_addr", mem_addr, 0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    reset_n = 1'b1;
    step();
    chk("rw.late_ack_valid", out_valid, 0);
    chk("rw.late_ack_req", mem_req, 0);
    chk("rw.late_ack_data", out_data, 0);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    lw = '{6'h23, 32'h0000_9000, 32'h0, 1'b0, 32'h1357_9BDF, 2, 1'b0, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF, 1'b1, 1'b0};
    run_vec(lw, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
